// File: rtl/rv_pkg.sv
// Shared RISC-V PE controller definitions: opcodes and fetch states.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DECODE,
    DONE
  } fetch_state_t;

  function automatic logic op_known(input logic [6:0] o);
    return o inside {OP_LOAD, OP_IMM, OP_AUIPC,
                     OP_STORE, OP_REG, OP_LUI,
                     OP_BRANCH, OP_JALR, OP_JAL};
  endfunction

endpackage

// File: rtl/rv_imm_select.sv
// Immediate selection and opcode legality from a latched IR.
module rv_imm_select
  import rv_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [31:0] ir,
  output logic [11:0] imm12,
  output logic [19:0] immhi,
  output logic        illegal
);

  logic is_s;
  logic is_b;

  assign is_s  = (op == OP_STORE);
  assign is_b  = (op == OP_BRANCH);
  assign immhi = ir[31:12];

  always_comb begin
    imm12 = ir[31:20];
    unique case (1'b1)
      is_s:    imm12 = {ir[31:25], ir[11:7]};
      is_b:    imm12 = {ir[31], ir[7],
                        ir[30:25], ir[11:8]};
      default: imm12 = ir[31:20];
    endcase
  end

  assign illegal = (ir[1:0] != 2'b11)
                 || !op_known(ir[6:0]);

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch over imem req/ack, IR latch and field decode
// for the RISC-V PE controller.
module instr_fetch_decode
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IRenable,
  input  logic [XLEN-1:0] pc_in,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [11:0]     imm12,
  output logic [19:0]     immhi,
  output logic            decodeComplete,
  output logic            illegal,
  output logic            fetch_error
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);

  fetch_state_t state, state_d;

  logic [31:0]   ir;
  logic [CW-1:0] cnt;
  logic          illegal_q;

  logic          launch;
  logic          misalign;
  logic          take_ack;
  logic          tmo;
  logic          tmo_hit;

  logic [11:0]   imm12_d;
  logic [19:0]   immhi_d;
  logic          illegal_d;

  rv_imm_select u_imm (
    .op      (ir[6:0]),
    .ir      (ir),
    .imm12   (imm12_d),
    .immhi   (immhi_d),
    .illegal (illegal_d)
  );

  assign tmo_hit = TMO_EN && (cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    launch   = 1'b0;
    misalign = 1'b0;
    take_ack = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (IRenable) begin
          if (pc_in[1:0] == 2'b00) begin
            launch  = 1'b1;
            state_d = WAIT;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      WAIT: begin
        if (imem_req && imem_ack) begin
          take_ack = 1'b1;
          state_d  = DECODE;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      DECODE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_req       <= 1'b0;
      imem_addr      <= '0;
      ir             <= '0;
      cnt            <= '0;
      fetch_error    <= 1'b0;
      decodeComplete <= 1'b0;
      op             <= '0;
      funct3         <= '0;
      funct7         <= '0;
      rs1            <= '0;
      rs2            <= '0;
      rd             <= '0;
      imm12          <= '0;
      immhi          <= '0;
      illegal_q      <= 1'b0;
    end else begin
      fetch_error <= misalign | tmo;
      if (launch) begin
        imem_req       <= 1'b1;
        imem_addr      <= pc_in;
        decodeComplete <= 1'b0;
      end
      if (take_ack | tmo) imem_req <= 1'b0;
      if (take_ack) ir <= imem_rdata;
      // counts WAIT cycles already spent without ack
      if (state == WAIT && state_d == WAIT)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if (state == DECODE) begin
        op             <= ir[6:0];
        funct3         <= ir[14:12];
        funct7         <= ir[31:25];
        rs1            <= ir[19:15];
        rs2            <= ir[24:20];
        rd             <= ir[11:7];
        imm12          <= imm12_d;
        immhi          <= immhi_d;
        illegal_q      <= illegal_d;
        decodeComplete <= 1'b1;
      end
    end
  end

  assign illegal = illegal_q & decodeComplete;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Randomized bench for instr_fetch_decode against a transaction-level model.
module tb_instr_fetch_decode;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRenable;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [11:0] imm12;
  logic [19:0] immhi;
  logic        decodeComplete;
  logic        illegal;
  logic        fetch_error;

  instr_fetch_decode #(
    .TIMEOUT_CYCLES (TMO),
    .XLEN           (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .IRenable       (IRenable),
    .pc_in          (pc_in),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .imm12          (imm12),
    .immhi          (immhi),
    .decodeComplete (decodeComplete),
    .illegal        (illegal),
    .fetch_error    (fetch_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm12;
    logic [19:0] immhi;
    logic        ill;
  } dec_t;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  logic        exp_req;
  logic [31:0] exp_addr;
  logic        exp_dc;
  logic        exp_err;
  dec_t        exp_f;

  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    int unsigned u;
    int unsigned o;
    u = w;
    o = u % 128;
    d.op    = 7'(o);
    d.f3    = 3'((u >> 12) % 8);
    d.f7    = 7'(u >> 25);
    d.rs1   = 5'((u >> 15) % 32);
    d.rs2   = 5'((u >> 20) % 32);
    d.rd    = 5'((u >> 7) % 32);
    d.immhi = 20'(u >> 12);
    if (o == 35)
      d.imm12 = 12'(((u >> 25) << 5) + ((u >> 7) % 32));
    else if (o == 99)
      d.imm12 = 12'((((u >> 31) % 2) << 11)
                  + (((u >> 7) % 2) << 10)
                  + (((u >> 25) % 64) << 4)
                  + ((u >> 8) % 16));
    else
      d.imm12 = 12'(u >> 20);
    d.ill = (u % 4 != 3) ||
      !(o inside {3, 19, 23, 35, 51, 55, 99, 103, 111});
    return d;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("imem_req", 32'(imem_req), 32'(exp_req));
      check("imem_addr", imem_addr, exp_addr);
      check("decodeComplete", 32'(decodeComplete), 32'(exp_dc));
      check("fetch_error", 32'(fetch_error), 32'(exp_err));
      check("op", 32'(op), 32'(exp_f.op));
      check("funct3", 32'(funct3), 32'(exp_f.f3));
      check("funct7", 32'(funct7), 32'(exp_f.f7));
      check("rs1", 32'(rs1), 32'(exp_f.rs1));
      check("rs2", 32'(rs2), 32'(exp_f.rs2));
      check("rd", 32'(rd), 32'(exp_f.rd));
      check("imm12", 32'(imm12), 32'(exp_f.imm12));
      check("immhi", 32'(immhi), 32'(exp_f.immhi));
      check("illegal", 32'(illegal),
            32'(exp_dc & exp_f.ill));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_zero();
    exp_req  = 1'b0;
    exp_addr = '0;
    exp_dc   = 1'b0;
    exp_err  = 1'b0;
    exp_f    = '0;
  endtask

  task automatic noise();
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
  endtask

  // d = WAIT cycles without ack before the ack; d >= TMO times out
  task automatic fetch(input logic [31:0] pc,
                       input logic [31:0] w,
                       input int d);
    int n;
    n = (d < TMO) ? d : TMO;
    IRenable = 1'b1;
    pc_in    = pc;
    noise();
    tick();
    exp_req  = 1'b1;
    exp_addr = pc;
    exp_dc   = 1'b0;
    for (int i = 0; i < n; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      IRenable   = 1'($urandom);
      pc_in      = $urandom;
      tick();
    end
    if (d < TMO) begin
      imem_ack   = 1'b1;
      imem_rdata = w;
      IRenable   = 1'($urandom);
      tick();
      exp_req  = 1'b0;
      noise();
      IRenable = 1'($urandom);
      tick();
      exp_dc   = 1'b1;
      exp_f    = ref_dec(w);
      IRenable = 1'b0;
      noise();
    end else begin
      exp_req  = 1'b0;
      exp_err  = 1'b1;
      IRenable = 1'b0;
      noise();
      tick();
      exp_err = 1'b0;
    end
  endtask

  task automatic misaligned(input logic [31:0] pc);
    IRenable = 1'b1;
    pc_in    = pc;
    noise();
    tick();
    exp_err  = 1'b1;
    IRenable = 1'b0;
    tick();
    exp_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      IRenable = 1'b0;
      pc_in    = $urandom;
      noise();
      tick();
    end
  endtask

  task automatic rst_pulse();
    reset    = 1'b1;
    IRenable = 1'($urandom);
    noise();
    tick();
    exp_zero();
    reset    = 1'b0;
    IRenable = 1'b0;
  endtask

  logic [6:0] ops [9] = '{7'd3, 7'd19, 7'd23, 7'd35,
                          7'd51, 7'd55, 7'd99, 7'd103, 7'd111};
  dec_t pin;

  initial begin
    logic [31:0] pc;
    logic [31:0] w;
    int k;
    reset      = 1'b1;
    IRenable   = 1'b0;
    pc_in      = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    exp_zero();
    tick();
    tick();
    cmp_on = 1'b1;
    reset  = 1'b0;
    idle(2);

    pin = ref_dec(32'h8015_0083);
    check("pin_lb_imm12", 32'(pin.imm12), 32'h801);
    check("pin_lb_rs1", 32'(pin.rs1), 32'd10);
    pin = ref_dec(32'hB041_9623);
    check("pin_sh_imm12", 32'(pin.imm12), 32'hB0C);
    pin = ref_dec(32'h0000_0000);
    check("pin_zero_ill", 32'(pin.ill), 32'd1);

    fetch(32'd4, 32'h8015_0083, 2);
    check("t1_addr", imem_addr, 32'd4);
    check("t1_op", 32'(op), 32'b0000011);
    check("t1_rs1", 32'(rs1), 32'b01010);
    check("t1_rd", 32'(rd), 32'b00001);
    check("t1_imm12", 32'(imm12), 32'b100000000001);
    check("t1_dc", 32'(decodeComplete), 32'd1);
    idle(1);

    fetch(32'h40, 32'h0136_4A33, 0);
    check("t2_op", 32'(op), 32'd51);
    check("t2_funct3", 32'(funct3), 32'b100);
    check("t2_rs2", 32'(rs2), 32'b10011);
    check("t2_rd", 32'(rd), 32'b10100);

    fetch(32'h44, 32'hB353_5637, 1);
    check("t3_immhi", 32'(immhi), 32'hB3535);
    fetch(32'h48, 32'hB041_9623, 0);
    check("t3_op", 32'(op), 32'd35);
    check("t3_imm12", 32'(imm12), 32'b101100001100);
    idle(1);

    fetch(32'h80, 32'h0000_0013, TMO);
    check("t4_req", 32'(imem_req), 32'd0);
    check("t4_dc", 32'(decodeComplete), 32'd0);
    fetch(32'h84, 32'h0000_0013, TMO - 1);
    check("t4_late_ack_dc", 32'(decodeComplete), 32'd1);

    misaligned(32'd6);
    fetch(32'h8, 32'h0000_0000, 0);
    check("t5_illegal", 32'(illegal), 32'd1);
    idle(1);

    IRenable = 1'b1;
    pc_in    = 32'h100;
    imem_ack = 1'b0;
    tick();
    exp_req  = 1'b1;
    exp_addr = 32'h100;
    exp_dc   = 1'b0;
    IRenable = 1'b0;
    reset    = 1'b1;
    tick();
    exp_zero();
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0136_4A33;
    tick();
    idle(3);
    check("t6_op", 32'(op), 32'd0);
    check("t6_dc", 32'(decodeComplete), 32'd0);

    IRenable = 1'b1;
    pc_in    = 32'h200;
    tick();
    exp_req  = 1'b1;
    exp_addr = 32'h200;
    IRenable = 1'b0;
    reset    = 1'b1;
    imem_ack = 1'b1;
    tick();
    exp_zero();
    reset = 1'b0;
    idle(3);
    check("t6b_rd", 32'(rd), 32'd0);

    for (int it = 0; it < 400; it++) begin
      k  = $urandom_range(0, 9);
      pc = $urandom;
      w  = $urandom;
      if (k < 7) begin
        pc[1:0] = 2'b00;
        if ($urandom_range(0, 1) == 1)
          w[6:0] = ops[$urandom_range(0, 8)];
        fetch(pc, w, $urandom_range(0, 5));
      end else if (k == 7) begin
        if (pc[1:0] == 2'b00) pc[0] = 1'b1;
        misaligned(pc);
      end else if (k == 8) begin
        idle($urandom_range(1, 3));
      end else begin
        rst_pulse();
      end
    end
    idle(2);
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
